l1_arbiter: RTL and testbench

Two-client arbiter between the instruction-side and data-side L1 caches and the single SDRAM controller bus. Each cache presents a level start/done request bus; the arbiter grants one at a time with round-robin priority, drives a registered request to the SDRAM controller, and routes completion back to the granted cache only. It sits directly downstream of both L1 caches' SDRAM-side buses.

---
 rtl/l1_arbiter.sv | 123 ++++++++++++
 tb/tb_l1_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/l1_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between the instruction and data L1 caches.
// Requests are registered toward the controller; completion is routed back combinationally.
module l1_arbiter #(
    parameter int addr_width = 32,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [addr_width-1:0] a_addr,
    input  logic [data_width-1:0] a_data,
    input  logic                  a_we,
    input  logic                  a_start,
    output logic [data_width-1:0] a_q,
    output logic                  a_done,
    input  logic [addr_width-1:0] b_addr,
    input  logic [data_width-1:0] b_data,
    input  logic                  b_we,
    input  logic                  b_start,
    output logic [data_width-1:0] b_q,
    output logic                  b_done,
    output logic [addr_width-1:0] sdc_addr,
    output logic [data_width-1:0] sdc_data,
    output logic                  sdc_we,
    output logic                  sdc_start,
    input  logic [data_width-1:0] sdc_q,
    input  logic                  sdc_done
);

    typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, GAP} state_t;

    state_t                state_q, state_d;
    logic                  served_a_q, served_a_d;
    logic                  served_b_q, served_b_d;
    logic                  last_b_q, last_b_d;
    logic [addr_width-1:0] sdc_addr_q, sdc_addr_d;
    logic [data_width-1:0] sdc_data_q, sdc_data_d;
    logic                  sdc_we_q, sdc_we_d;
    logic                  sdc_start_q, sdc_start_d;
    logic                  elig_a, elig_b;

    assign a_done    = sdc_done & (state_q == BUSY_A);
    assign b_done    = sdc_done & (state_q == BUSY_B);
    assign a_q       = sdc_q;
    assign b_q       = sdc_q;
    assign sdc_addr  = sdc_addr_q;
    assign sdc_data  = sdc_data_q;
    assign sdc_we    = sdc_we_q;
    assign sdc_start = sdc_start_q;

    // A start held across its own done stays blocked until it is released.
    assign elig_a = a_start & ~served_a_q;
    assign elig_b = b_start & ~served_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            served_a_q  <= 1'b0;
            served_b_q  <= 1'b0;
            last_b_q    <= 1'b1;
            sdc_addr_q  <= '0;
            sdc_data_q  <= '0;
            sdc_we_q    <= 1'b0;
            sdc_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            served_a_q  <= served_a_d;
            served_b_q  <= served_b_d;
            last_b_q    <= last_b_d;
            sdc_addr_q  <= sdc_addr_d;
            sdc_data_q  <= sdc_data_d;
            sdc_we_q    <= sdc_we_d;
            sdc_start_q <= sdc_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        sdc_addr_d  = sdc_addr_q;
        sdc_data_d  = sdc_data_q;
        sdc_we_d    = sdc_we_q;
        sdc_start_d = sdc_start_q;
        // A released start always clears served, even on the cycle of its own done.
        served_a_d  = a_start ? (served_a_q | a_done) : 1'b0;
        served_b_d  = b_start ? (served_b_q | b_done) : 1'b0;

        case (state_q)
            IDLE: begin
                sdc_start_d = 1'b0;
                if (elig_a && (!elig_b || last_b_q)) begin
                    state_d     = BUSY_A;
                    last_b_d    = 1'b0;
                    sdc_addr_d  = a_addr;
                    sdc_data_d  = a_data;
                    sdc_we_d    = a_we;
                    sdc_start_d = 1'b1;
                end else if (elig_b) begin
                    state_d     = BUSY_B;
                    last_b_d    = 1'b1;
                    sdc_addr_d  = b_addr;
                    sdc_data_d  = b_data;
                    sdc_we_d    = b_we;
                    sdc_start_d = 1'b1;
                end
            end
            BUSY_A, BUSY_B: begin
                if (sdc_done) begin
                    state_d     = GAP;
                    sdc_start_d = 1'b0;
                end
            end
            GAP: begin
                state_d     = IDLE;
                sdc_start_d = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                sdc_start_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_arbiter.sv
// Randomized bench for l1_arbiter: a transaction-level model predicts every output each cycle,
// with a few directed scenarios for the latency, reset and round-robin corner cases.
module tb_l1_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] aAddr, aData, bAddr, bData, sdcQ;
    logic        aWe, aStart, bWe, bStart, sdcDone;
    logic [31:0] aQ, bQ, sdcAddr, sdcData;
    logic        aDone, bDone, sdcWe, sdcStart;

    int checks = 0;
    int failures = 0;

    // Model: who owns the controller, earliest edge a new grant may happen, and fairness history.
    int          edgeNo = 0;
    int          owner = 0;
    int          grantEdge = 0;
    int          lastGrant = 2;
    bit          servedA = 0, servedB = 0;
    logic        mStart = 0, mWe = 0;
    logic [31:0] mAddr = 0, mData = 0;
    bit          respArmed = 0;
    int          respLat = 0;

    l1_arbiter #(.addr_width(32), .data_width(32)) dut (
        .clk(clk), .reset(reset),
        .a_addr(aAddr), .a_data(aData), .a_we(aWe), .a_start(aStart), .a_q(aQ), .a_done(aDone),
        .b_addr(bAddr), .b_data(bData), .b_we(bWe), .b_start(bStart), .b_q(bQ), .b_done(bDone),
        .sdc_addr(sdcAddr), .sdc_data(sdcData), .sdc_we(sdcWe), .sdc_start(sdcStart),
        .sdc_q(sdcQ), .sdc_done(sdcDone)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at edge %0d", tag, observed, expected, edgeNo);
        end
    endtask

    task automatic modelClock();
        bit eligA, eligB, doneA, doneB;
        int pick;
        edgeNo++;
        if (reset) begin
            owner = 0; grantEdge = edgeNo + 1; lastGrant = 2;
            servedA = 0; servedB = 0;
            mStart = 0; mWe = 0; mAddr = 0; mData = 0;
            respArmed = 0;
            return;
        end
        eligA = aStart && !servedA;
        eligB = bStart && !servedB;
        doneA = sdcDone && owner == 1;
        doneB = sdcDone && owner == 2;
        servedA = aStart ? (servedA || doneA) : 0;
        servedB = bStart ? (servedB || doneB) : 0;
        if (owner != 0) begin
            if (sdcDone) begin
                owner = 0;
                mStart = 0;
                grantEdge = edgeNo + 2;
            end
        end else if (edgeNo >= grantEdge) begin
            pick = 0;
            if (eligA && eligB) pick = (lastGrant == 2) ? 1 : 2;
            else if (eligA) pick = 1;
            else if (eligB) pick = 2;
            if (pick != 0) begin
                owner = pick;
                lastGrant = pick;
                mStart = 1;
                mAddr = (pick == 1) ? aAddr : bAddr;
                mData = (pick == 1) ? aData : bData;
                mWe   = (pick == 1) ? aWe : bWe;
            end
        end
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic applyStimulus();
        #1;
        checkOutput("sdc_start", sdcStart, mStart);
        checkOutput("sdc_addr", sdcAddr, mAddr);
        checkOutput("sdc_data", sdcData, mData);
        checkOutput("sdc_we", sdcWe, mWe);
        checkOutput("a_done", aDone, sdcDone && owner == 1);
        checkOutput("b_done", bDone, sdcDone && owner == 2);
        checkOutput("a_q", aQ, sdcQ);
        checkOutput("b_q", bQ, sdcQ);
        @(posedge clk);
        modelClock();
        @(negedge clk);
    endtask

    task automatic randomClient(inout logic start, inout logic [31:0] addr, inout logic [31:0] data, inout logic we);
        if (!start) begin
            if ($urandom_range(0, 2) == 0) begin
                start = 1;
                addr = $urandom;
                data = $urandom;
                we = 1'($urandom_range(0, 1));
            end
        end else if ($urandom_range(0, 5) == 0) begin
            start = 0;
        end else if ($urandom_range(0, 4) == 0) begin
            addr = $urandom;
            data = $urandom;
        end
    endtask

    initial begin
        reset = 1; aStart = 0; bStart = 0; aWe = 0; bWe = 0;
        aAddr = 0; aData = 0; bAddr = 0; bData = 0; sdcQ = 0; sdcDone = 0;
        @(posedge clk);
        modelClock();
        @(negedge clk);
        applyStimulus();
        reset = 0;
        applyStimulus();

        // Single A read with a 5-cycle controller latency.
        aStart = 1; aAddr = 32'h000123; aWe = 0;
        applyStimulus();
        checkOutput("t1_start_rise", sdcStart, 1);
        checkOutput("t1_addr", sdcAddr, 32'h000123);
        repeat (4) applyStimulus();
        sdcDone = 1; sdcQ = 32'hDEADBEEF;
        #1;
        checkOutput("t1_a_done", aDone, 1);
        checkOutput("t1_a_q", aQ, 32'hDEADBEEF);
        checkOutput("t1_b_done", bDone, 0);
        applyStimulus();
        sdcDone = 0; aStart = 0;
        repeat (2) applyStimulus();

        // Reset in the middle of a B write, then a tie must go to A.
        bStart = 1; bWe = 1; bData = 32'h55AA55AA; bAddr = 32'hB0; aAddr = 32'hA0;
        repeat (2) applyStimulus();
        checkOutput("rst_b_granted", sdcStart, 1);
        reset = 1;
        applyStimulus();
        reset = 0;
        checkOutput("rst_start", sdcStart, 0);
        checkOutput("rst_we", sdcWe, 0);
        checkOutput("rst_addr", sdcAddr, 0);
        aStart = 1;
        applyStimulus();
        checkOutput("rst_tie_a", sdcAddr, 32'hA0);
        sdcDone = 1;
        applyStimulus();
        sdcDone = 0; aStart = 0;
        repeat (3) applyStimulus();
        checkOutput("rr_then_b", sdcAddr, 32'hB0);
        sdcDone = 1;
        applyStimulus();
        sdcDone = 0;
        repeat (4) applyStimulus();
        checkOutput("held_b_no_regrant", sdcStart, 0);
        bStart = 0;
        repeat (2) applyStimulus();

        // Random traffic, random controller latency, stray dones and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            randomClient(aStart, aAddr, aData, aWe);
            randomClient(bStart, bAddr, bData, bWe);
            sdcQ = $urandom;
            sdcDone = 0;
            if (owner != 0 && !respArmed) begin
                respArmed = 1;
                respLat = $urandom_range(1, 6);
            end
            if (respArmed) begin
                respLat--;
                if (respLat == 0) begin
                    sdcDone = 1;
                    respArmed = 0;
                end
            end else if (owner == 0) begin
                sdcDone = ($urandom_range(0, 9) == 0);
            end
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
